ble_cmd_framer: RTL and testbench

- Sequences the raw byte stream from the BLE UART receiver (8-bit data + 1-cycle valid strobe) into checked, framed commands for the gameplay controller.
- Frame format: SYNC, CMD, LEN, LEN payload bytes, CHK.
- Delivers each good frame over a valid/ready handshake.
- Discards malformed, stalled or unaccepted frames and counts them as errors.

---
 rtl/ble_cmd_framer.sv | 199 +++++++++++++++++++
 tb/tb_ble_cmd_framer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ble_cmd_framer.sv
// ble_cmd_framer: turns the raw BLE UART byte stream into checked command frames
// (SYNC, CMD, LEN, payload, CHK) and hands good frames to the gameplay controller
// over a valid/ready handshake. Malformed, stalled or unaccepted frames are dropped
// and counted.
module ble_cmd_framer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 4,
    parameter int         TIMEOUT_CYCLES = 74250
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    output logic [7:0]  cmd_out,
    output logic [31:0] arg_out,
    output logic [2:0]  len_out,
    output logic        cmd_valid_out,
    input  logic        cmd_ready_in,
    output logic        busy_out,
    output logic [7:0]  err_count_out,
    output logic [1:0]  last_err_out
);
    localparam int            TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_CHK = 2'd0;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;
    localparam logic [1:0] ERR_OVF = 2'd3;

    typedef enum logic [2:0] {S_HUNT, S_CMD, S_LEN, S_PAYLOAD, S_CHECK} state_e;

    state_e        state_q, state_d;
    logic [7:0]    cmdw_q, cmdw_d;      // command of the frame being assembled
    logic [2:0]    lenw_q, lenw_d;      // length of the frame being assembled
    logic [31:0]   argw_q, argw_d;      // payload of the frame being assembled
    logic [7:0]    chk_q, chk_d;        // running XOR of CMD, LEN and payload
    logic [1:0]    idx_q, idx_d;        // next payload byte slot
    logic [TW-1:0] tcnt_q, tcnt_d;      // idle cycles since the last byte in a frame
    logic [7:0]    cmd_q, cmd_d;
    logic [31:0]   arg_q, arg_d;
    logic [2:0]    len_q, len_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic [7:0]    errc_q, errc_d;
    logic [1:0]    lerr_q, lerr_d;

    logic          good;
    logic          err_hit;
    logic [1:0]    err_code;

    // Register all framer state; reset abandons any frame without counting it
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_HUNT;
            cmdw_q  <= '0;
            lenw_q  <= '0;
            argw_q  <= '0;
            chk_q   <= '0;
            idx_q   <= '0;
            tcnt_q  <= '0;
            cmd_q   <= '0;
            arg_q   <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            errc_q  <= '0;
            lerr_q  <= '0;
        end else begin
            state_q <= state_d;
            cmdw_q  <= cmdw_d;
            lenw_q  <= lenw_d;
            argw_q  <= argw_d;
            chk_q   <= chk_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            errc_q  <= errc_d;
            lerr_q  <= lerr_d;
        end
    end

    // Frame parsing, idle timeout, delivery handshake and error accounting
    always_comb begin
        state_d  = state_q;
        cmdw_d   = cmdw_q;
        lenw_d   = lenw_q;
        argw_d   = argw_q;
        chk_d    = chk_q;
        idx_d    = idx_q;
        tcnt_d   = tcnt_q;
        cmd_d    = cmd_q;
        arg_d    = arg_q;
        len_d    = len_q;
        valid_d  = valid_q;
        errc_d   = errc_q;
        lerr_d   = lerr_q;
        good     = 1'b0;
        err_hit  = 1'b0;
        err_code = ERR_CHK;

        if (valid_q && cmd_ready_in) begin
            valid_d = 1'b0;
        end

        if (byte_valid_in) begin
            // A byte always wins over an expiring timeout
            tcnt_d = '0;
            case (state_q)
                S_HUNT: begin
                    if (byte_in == SYNC_BYTE) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    cmdw_d  = byte_in;
                    chk_d   = byte_in;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    if (byte_in > MAX_LEN_B) begin
                        err_hit  = 1'b1;
                        err_code = ERR_LEN;
                        state_d  = S_HUNT;
                    end else begin
                        lenw_d  = byte_in[2:0];
                        argw_d  = '0;
                        idx_d   = '0;
                        chk_d   = chk_q ^ byte_in;
                        state_d = (byte_in == 8'd0) ? S_CHECK : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    argw_d[{idx_q, 3'b000} +: 8] = byte_in;
                    chk_d = chk_q ^ byte_in;
                    idx_d = idx_q + 2'd1;
                    if ({1'b0, idx_q} == (lenw_q - 3'd1)) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (byte_in == chk_q) begin
                        good = 1'b1;
                    end else begin
                        err_hit  = 1'b1;
                        err_code = ERR_CHK;
                    end
                    state_d = S_HUNT;
                end
                default: state_d = S_HUNT;
            endcase
        end else if (state_q != S_HUNT) begin
            if (tcnt_q == T_LAST) begin
                err_hit  = 1'b1;
                err_code = ERR_TMO;
                state_d  = S_HUNT;
                tcnt_d   = '0;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end

        if (good) begin
            // A pending, unaccepted command keeps its outputs; the new frame is lost
            if (valid_q && !cmd_ready_in) begin
                err_hit  = 1'b1;
                err_code = ERR_OVF;
            end else begin
                cmd_d   = cmdw_q;
                arg_d   = argw_q;
                len_d   = lenw_q;
                valid_d = 1'b1;
            end
        end

        if (err_hit) begin
            if (errc_q != 8'hFF) begin
                errc_d = errc_q + 8'd1;
            end
            lerr_d = err_code;
        end

        busy_d = (state_d != S_HUNT);
    end

    assign cmd_out       = cmd_q;
    assign arg_out       = arg_q;
    assign len_out       = len_q;
    assign cmd_valid_out = valid_q;
    assign busy_out      = busy_q;
    assign err_count_out = errc_q;
    assign last_err_out  = lerr_q;

endmodule

// File: tb/tb_ble_cmd_framer.sv
// Testbench for ble_cmd_framer: directed frames plus randomized traffic, compared
// every cycle against a byte-queue reference model of the framing rules.
module tb_ble_cmd_framer;
    localparam int         T    = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_i;
    logic        bv;
    logic        ready;
    logic [7:0]  cmd_o;
    logic [31:0] arg_o;
    logic [2:0]  len_o;
    logic        valid_o;
    logic        busy_o;
    logic [7:0]  errc_o;
    logic [1:0]  lerr_o;

    ble_cmd_framer #(
        .SYNC_BYTE     (8'hA5),
        .MAX_LEN       (4),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .byte_in      (byte_i),
        .byte_valid_in(bv),
        .cmd_out      (cmd_o),
        .arg_out      (arg_o),
        .len_out      (len_o),
        .cmd_valid_out(valid_o),
        .cmd_ready_in (ready),
        .busy_out     (busy_o),
        .err_count_out(errc_o),
        .last_err_out (lerr_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit          in_frame;
    logic [7:0]  fq[$];
    int          idle;
    logic [7:0]  m_cmd;
    logic [31:0] m_arg;
    logic [2:0]  m_len;
    bit          m_valid;
    int          m_errs;
    logic [1:0]  m_last;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        in_frame = 1'b0;
        fq.delete();
        idle    = 0;
        m_cmd   = '0;
        m_arg   = '0;
        m_len   = '0;
        m_valid = 1'b0;
        m_errs  = 0;
        m_last  = '0;
    endfunction

    function automatic void model_error(input logic [1:0] code);
        if (m_errs < 255) m_errs++;
        m_last = code;
    endfunction

    // One clock edge of the framing rules, given the inputs seen at that edge
    function automatic void model_step(input bit v, input logic [7:0] b, input bit rdy);
        bit         good;
        logic [7:0] x;
        logic [7:0] l;
        good = 1'b0;
        if (v) begin
            idle = 0;
            if (!in_frame) begin
                if (b == SYNC) begin
                    in_frame = 1'b1;
                    fq.delete();
                end
            end else begin
                fq.push_back(b);
                l = (fq.size() >= 2) ? fq[1] : 8'd0;
                if (fq.size() == 2 && l > 8'd4) begin
                    model_error(2'd1);
                    in_frame = 1'b0;
                end else if (fq.size() >= 3 && fq.size() == 3 + int'(l)) begin
                    x = 8'd0;
                    for (int i = 0; i < fq.size() - 1; i++) x ^= fq[i];
                    if (x == fq[fq.size() - 1]) good = 1'b1;
                    else model_error(2'd0);
                    in_frame = 1'b0;
                end
            end
        end else if (in_frame) begin
            idle++;
            if (idle == T) begin
                model_error(2'd2);
                in_frame = 1'b0;
                idle = 0;
            end
        end
        if (good) begin
            if (m_valid && !rdy) begin
                model_error(2'd3);
            end else begin
                l       = fq[1];
                m_cmd   = fq[0];
                m_len   = l[2:0];
                m_arg   = '0;
                for (int i = 0; i < int'(l); i++) m_arg[8*i +: 8] = fq[2 + i];
                m_valid = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic compare_all();
        check_eq("cmd_out", cmd_o, m_cmd);
        check_eq("arg_out", arg_o, m_arg);
        check_eq("len_out", len_o, m_len);
        check_eq("cmd_valid_out", valid_o, m_valid);
        check_eq("busy_out", busy_o, in_frame);
        check_eq("err_count_out", errc_o, m_errs);
        check_eq("last_err_out", lerr_o, m_last);
    endtask

    task automatic cycle(input bit v, input logic [7:0] b, input bit rdy);
        @(negedge clk);
        bv     = v;
        byte_i = b;
        ready  = rdy;
        @(posedge clk);
        model_step(v, b, rdy);
        #1;
        compare_all();
    endtask

    task automatic rcycle(input bit v, input logic [7:0] b);
        cycle(v, b, $urandom_range(0, 3) != 0);
    endtask

    task automatic send_bytes(input int n, input logic [63:0] pk, input bit rdy);
        logic [63:0] s;
        s = pk;
        for (int i = n - 1; i >= 0; i--) cycle(1'b1, s[8*i +: 8], rdy);
    endtask

    task automatic idle_cycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy);
    endtask

    task automatic rand_frame();
        logic [7:0] fb[$];
        logic [7:0] x;
        int         len;
        int         kind;
        kind = int'($urandom_range(0, 9));
        if (kind == 2) begin
            repeat ($urandom_range(1, 3)) rcycle(1'b1, 8'($urandom));
        end
        fb.push_back(SYNC);
        fb.push_back(($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom));
        if (kind == 0) len = int'($urandom_range(5, 255));
        else           len = int'($urandom_range(0, 4));
        fb.push_back(8'(len));
        if (len <= 4) begin
            for (int i = 0; i < len; i++) fb.push_back(($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom));
            x = 8'd0;
            for (int i = 1; i < fb.size(); i++) x ^= fb[i];
            if (kind == 1) x ^= 8'(1 << $urandom_range(0, 7));
            fb.push_back(x);
        end
        foreach (fb[i]) begin
            if ($urandom_range(0, 24) == 0) begin
                repeat ($urandom_range(13, 17)) rcycle(1'b0, 8'h00);
            end else begin
                repeat ($urandom_range(0, 1)) rcycle(1'b0, 8'h00);
            end
            rcycle(1'b1, fb[i]);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        bv     = 1'b0;
        byte_i = 8'h00;
        ready  = 1'b0;
        model_reset();
        #1;
        compare_all();
        #21;
        rst_n = 1'b1;

        // good frame, ready high
        send_bytes(6, 64'hA5_10_02_34_12_34, 1'b1);
        check_eq("good_cmd", cmd_o, 32'h10);
        check_eq("good_arg", arg_o, 32'h0000_1234);
        check_eq("good_len", len_o, 32'd2);
        check_eq("good_valid", valid_o, 32'd1);
        idle_cycles(1, 1'b1);
        check_eq("good_valid_drop", valid_o, 32'd0);
        check_eq("good_errs", errc_o, 32'd0);

        // zero-length frame
        send_bytes(4, 64'hA5_07_00_07, 1'b1);
        check_eq("zl_cmd", cmd_o, 32'h07);
        check_eq("zl_arg", arg_o, 32'h0);
        check_eq("zl_len", len_o, 32'd0);
        idle_cycles(1, 1'b1);

        // bad checksum, then bad length
        send_bytes(6, 64'hA5_10_02_34_12_00, 1'b1);
        idle_cycles(1, 1'b1);
        check_eq("chk_valid", valid_o, 32'd0);
        check_eq("chk_errs", errc_o, 32'd1);
        check_eq("chk_code", lerr_o, 32'd0);
        send_bytes(3, 64'hA5_10_05, 1'b1);
        check_eq("len_errs", errc_o, 32'd2);
        check_eq("len_code", lerr_o, 32'd1);
        check_eq("len_busy", busy_o, 32'd0);

        // backpressure: second good frame overflows
        send_bytes(6, 64'hA5_10_02_34_12_34, 1'b0);
        send_bytes(5, 64'hA5_20_01_55_74, 1'b0);
        check_eq("bp_cmd", cmd_o, 32'h10);
        check_eq("bp_arg", arg_o, 32'h1234);
        check_eq("bp_valid", valid_o, 32'd1);
        check_eq("bp_errs", errc_o, 32'd3);
        check_eq("bp_code", lerr_o, 32'd3);
        idle_cycles(1, 1'b1);
        check_eq("bp_accept_drop", valid_o, 32'd0);

        // timeout after silence
        send_bytes(2, 64'hA5_10, 1'b1);
        idle_cycles(T - 1, 1'b1);
        check_eq("tmo_busy_before", busy_o, 32'd1);
        idle_cycles(1, 1'b1);
        check_eq("tmo_busy_after", busy_o, 32'd0);
        check_eq("tmo_code", lerr_o, 32'd2);
        check_eq("tmo_errs", errc_o, 32'd4);

        // byte on the expiry cycle keeps the frame alive
        send_bytes(2, 64'hA5_10, 1'b1);
        idle_cycles(T - 1, 1'b1);
        send_bytes(1, 64'h02, 1'b1);
        check_eq("exp_busy", busy_o, 32'd1);
        check_eq("exp_errs", errc_o, 32'd4);
        send_bytes(3, 64'h11_22_21, 1'b1);
        check_eq("exp_cmd", cmd_o, 32'h10);
        check_eq("exp_arg", arg_o, 32'h2211);
        check_eq("exp_valid", valid_o, 32'd1);
        idle_cycles(1, 1'b1);

        // asynchronous reset mid-payload
        send_bytes(4, 64'hA5_10_03_11, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        send_bytes(5, 64'hA5_33_01_44_76, 1'b1);
        check_eq("rst_cmd", cmd_o, 32'h33);
        check_eq("rst_arg", arg_o, 32'h44);
        check_eq("rst_len", len_o, 32'd1);
        check_eq("rst_errs", errc_o, 32'd0);
        idle_cycles(1, 1'b1);

        // randomized traffic
        for (int k = 0; k < 300; k++) rand_frame();
        idle_cycles(T + 2, 1'b1);

        // error counter saturation
        for (int k = 0; k < 260; k++) send_bytes(3, 64'hA5_00_09, 1'b1);
        check_eq("sat_errs", errc_o, 32'd255);
        check_eq("sat_code", lerr_o, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
